// File: rtl/byte_strip.sv
`default_nettype none
// ============================================================================
// Module   : byte_strip
// Purpose  : Round-robin byte striper onto four lanes; a full group of four
//            is presented on all lanes together with a one-cycle strobe.
//            Define BYTE_STRIP_PAD_EN to flush partial groups with PAD_BYTE.
// Revision : 1.0 - initial release
// ============================================================================
module byte_strip #(
    parameter logic [7:0] PAD_BYTE = 8'hF7
) (
    input  logic       CLK,
    input  logic       RESET_L,
    input  logic [7:0] D,
    input  logic       DK,
    input  logic       IN_VALID,
    output logic [7:0] LANE0,
    output logic [7:0] LANE1,
    output logic [7:0] LANE2,
    output logic [7:0] LANE3,
    output logic       DK_0,
    output logic       DK_1,
    output logic       DK_2,
    output logic       DK_3,
    output logic       LANE_VALID,
    output logic [1:0] LANE_IDX
);

    localparam logic [1:0] C_LAST_LANE = 2'd3;

    logic [7:0] r_sh_d [0:2];
    logic       r_sh_k [0:2];
    logic [7:0] r_lane0, r_lane1, r_lane2, r_lane3;
    logic       r_dk0, r_dk1, r_dk2, r_dk3;
    logic       r_lane_valid;
    logic [1:0] r_lane_idx;

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            for (int i = 0; i < 3; i++) begin
                r_sh_d[i] <= 8'h00;
                r_sh_k[i] <= 1'b0;
            end
            r_lane0      <= 8'h00;
            r_lane1      <= 8'h00;
            r_lane2      <= 8'h00;
            r_lane3      <= 8'h00;
            r_dk0        <= 1'b0;
            r_dk1        <= 1'b0;
            r_dk2        <= 1'b0;
            r_dk3        <= 1'b0;
            r_lane_valid <= 1'b0;
            r_lane_idx   <= 2'd0;
        end else begin
            r_lane_valid <= 1'b0;
            if (IN_VALID) begin
                if (r_lane_idx == C_LAST_LANE) begin
                    // Fourth byte completes the group: shadows plus the live byte
                    r_lane0      <= r_sh_d[0];
                    r_lane1      <= r_sh_d[1];
                    r_lane2      <= r_sh_d[2];
                    r_lane3      <= D;
                    r_dk0        <= r_sh_k[0];
                    r_dk1        <= r_sh_k[1];
                    r_dk2        <= r_sh_k[2];
                    r_dk3        <= DK;
                    r_lane_valid <= 1'b1;
                    r_lane_idx   <= 2'd0;
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        if (r_lane_idx == 2'(i)) begin
                            r_sh_d[i] <= D;
                            r_sh_k[i] <= DK;
                        end
                    end
                    r_lane_idx <= r_lane_idx + 2'd1;
                end
            end
`ifdef BYTE_STRIP_PAD_EN
            else if (r_lane_idx != 2'd0) begin
                // Lane 0 is always populated here since at least one byte is held
                r_lane0      <= r_sh_d[0];
                r_dk0        <= r_sh_k[0];
                r_lane1      <= (r_lane_idx > 2'd1) ? r_sh_d[1] : PAD_BYTE;
                r_dk1        <= (r_lane_idx > 2'd1) ? r_sh_k[1] : 1'b1;
                r_lane2      <= (r_lane_idx > 2'd2) ? r_sh_d[2] : PAD_BYTE;
                r_dk2        <= (r_lane_idx > 2'd2) ? r_sh_k[2] : 1'b1;
                r_lane3      <= PAD_BYTE;
                r_dk3        <= 1'b1;
                r_lane_valid <= 1'b1;
                r_lane_idx   <= 2'd0;
            end
`endif
        end
    end

`ifndef BYTE_STRIP_PAD_EN
    logic w_pad_unused;
    assign w_pad_unused = ^PAD_BYTE;
`endif

    assign LANE0      = r_lane0;
    assign LANE1      = r_lane1;
    assign LANE2      = r_lane2;
    assign LANE3      = r_lane3;
    assign DK_0       = r_dk0;
    assign DK_1       = r_dk1;
    assign DK_2       = r_dk2;
    assign DK_3       = r_dk3;
    assign LANE_VALID = r_lane_valid;
    assign LANE_IDX   = r_lane_idx;

endmodule
`default_nettype wire

// File: tb/tb_byte_strip.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_strip
// Purpose  : Scoreboard bench for byte_strip; expected groups are queued as
//            stimulus is driven and popped whenever LANE_VALID is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_byte_strip;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d;
    logic       dk;
    logic       in_valid;
    logic [7:0] lane0, lane1, lane2, lane3;
    logic       k0, k1, k2, k3;
    logic       lane_valid;
    logic [1:0] lane_idx;

    always #5 clk = ~clk;

    byte_strip dut (
        .CLK        (clk),
        .RESET_L    (rst_n),
        .D          (d),
        .DK         (dk),
        .IN_VALID   (in_valid),
        .LANE0      (lane0),
        .LANE1      (lane1),
        .LANE2      (lane2),
        .LANE3      (lane3),
        .DK_0       (k0),
        .DK_1       (k1),
        .DK_2       (k2),
        .DK_3       (k3),
        .LANE_VALID (lane_valid),
        .LANE_IDX   (lane_idx)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
    } grp_t;

    grp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   strobes     = 0;

    // Scoreboard: every strobe must match the oldest queued group
    always @(negedge clk) begin
        if (rst_n === 1'b1 && lane_valid === 1'b1) begin
            strobes++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_strobe: lanes=%h dk=%b, no group expected",
                         {lane3, lane2, lane1, lane0}, {k3, k2, k1, k0});
            end else begin
                grp_t e;
                e = exp_q.pop_front();
                if ({lane3, lane2, lane1, lane0} !== e.d || {k3, k2, k1, k0} !== e.k) begin
                    miscompares++;
                    $display("FAIL group: lanes=%h dk=%b, expected lanes=%h dk=%b",
                             {lane3, lane2, lane1, lane0}, {k3, k2, k1, k0}, e.d, e.k);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic push_grp(input logic [31:0] dd, input logic [3:0] kk);
        grp_t g;
        g.d = dd;
        g.k = kk;
        exp_q.push_back(g);
    endtask

    task automatic drive(input logic v, input logic [7:0] b, input logic k);
        @(negedge clk);
        in_valid = v;
        d        = b;
        dk       = k;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({lane3, lane2, lane1, lane0} !== 32'h0 || {k3, k2, k1, k0} !== 4'b0) begin
            miscompares++;
            $display("FAIL por_lanes: lanes=%h dk=%b, expected 0", {lane3, lane2, lane1, lane0}, {k3, k2, k1, k0});
        end
        vectors++;
        if (lane_valid !== 1'b0 || lane_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL por_ctrl: valid=%b idx=%0d, expected 0/0", lane_valid, lane_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full_rate();
        int   s0;
        logic exp_v;
        s0 = strobes;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp_v = (((i - 1) % 4) == 3);
                vectors++;
                if (lane_valid !== exp_v) begin
                    miscompares++;
                    $display("FAIL full_strobe_timing[%0d]: valid=%b, expected %b", i, lane_valid, exp_v);
                end
            end
            vectors++;
            if (lane_idx !== 2'(i % 4)) begin
                miscompares++;
                $display("FAIL full_idx[%0d]: idx=%0d, expected %0d", i, lane_idx, i % 4);
            end
            if (i == 3) push_grp(32'h13121110, 4'b0000);
            if (i == 7) push_grp(32'h17161514, 4'b0000);
            in_valid = (i < 8);
            d        = (i < 8) ? 8'(8'h10 + i) : 8'h00;
            dk       = 1'b0;
        end
        drive(0, 8'h00, 0);
        drive(0, 8'h00, 0);
        vectors++;
        if (strobes - s0 !== 2) begin
            miscompares++;
            $display("FAIL full_strobe_count: got %0d, expected 2", strobes - s0);
        end
        vectors++;
        if ({lane3, lane2, lane1, lane0} !== 32'h17161514 || lane_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL full_hold: lanes=%h valid=%b, expected 17161514/0", {lane3, lane2, lane1, lane0}, lane_valid);
        end
    endtask

    task automatic test_k_flags();
        int s0;
        s0 = strobes;
        drive(1, 8'hBC, 1);
        drive(1, 8'h01, 0);
        drive(1, 8'h02, 0);
        push_grp(32'h1C0201BC, 4'b1001);
        drive(1, 8'h1C, 1);
        drive(0, 8'h00, 0);
        drive(0, 8'h00, 0);
        vectors++;
        if ({k3, k2, k1, k0} !== 4'b1001 || strobes - s0 !== 1) begin
            miscompares++;
            $display("FAIL k_flags: dk=%b strobes=%0d, expected 1001/1", {k3, k2, k1, k0}, strobes - s0);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({lane3, lane2, lane1, lane0} !== 32'h0 || {k3, k2, k1, k0} !== 4'b0 ||
            lane_valid !== 1'b0 || lane_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL async_reset: lanes=%h dk=%b valid=%b idx=%0d, expected all 0",
                     {lane3, lane2, lane1, lane0}, {k3, k2, k1, k0}, lane_valid, lane_idx);
        end
        #1 rst_n = 1'b1;
    endtask

`ifndef BYTE_STRIP_PAD_EN
    task automatic test_gapped();
        logic       v_seq   [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] d_seq   [7] = '{8'hA0, 8'h00, 8'hA1, 8'h00, 8'h00, 8'hA2, 8'hA3};
        logic [1:0] exp_idx [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
        int s0;
        s0 = strobes;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors++;
            if (lane_idx !== exp_idx[i]) begin
                miscompares++;
                $display("FAIL gap_idx[%0d]: idx=%0d, expected %0d", i, lane_idx, exp_idx[i]);
            end
            if (i == 6) push_grp(32'hA3A2A1A0, 4'b0000);
            in_valid = (i < 7) ? v_seq[i] : 1'b0;
            d        = (i < 7) ? d_seq[i] : 8'h00;
            dk       = 1'b0;
        end
        drive(0, 8'h00, 0);
        drive(0, 8'h00, 0);
        vectors++;
        if (strobes - s0 !== 1) begin
            miscompares++;
            $display("FAIL gap_strobe_count: got %0d, expected 1", strobes - s0);
        end
    endtask
`else
    task automatic test_pad();
        int s0;
        s0 = strobes;
        drive(1, 8'h55, 0);
        drive(1, 8'h66, 0);
        @(negedge clk);
        vectors++;
        if (lane_idx !== 2'd2) begin
            miscompares++;
            $display("FAIL pad_idx_before: idx=%0d, expected 2", lane_idx);
        end
        push_grp(32'hF7F76655, 4'b1100);
        in_valid = 1'b0;
        d        = 8'h00;
        dk       = 1'b0;
        drive(0, 8'h00, 0);
        drive(0, 8'h00, 0);
        drive(0, 8'h00, 0);
        vectors++;
        if (strobes - s0 !== 1 || lane_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL pad_strobe_count: strobes=%0d idx=%0d, expected 1/0", strobes - s0, lane_idx);
        end
    endtask
`endif

    task automatic test_reset_mid_group();
        int s0;
        s0 = strobes;
        drive(1, 8'h01, 0);
        drive(1, 8'h02, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #2 rst_n = 1'b1;
        vectors++;
        if (lane_idx !== 2'd0 || lane0 !== 8'h00) begin
            miscompares++;
            $display("FAIL midgrp_reset: idx=%0d lane0=%h, expected 0/00", lane_idx, lane0);
        end
        drive(1, 8'h03, 0);
        drive(1, 8'h04, 0);
        drive(1, 8'h05, 0);
        push_grp(32'h06050403, 4'b0000);
        drive(1, 8'h06, 0);
        drive(0, 8'h00, 0);
        drive(0, 8'h00, 0);
        vectors++;
        if (strobes - s0 !== 1) begin
            miscompares++;
            $display("FAIL midgrp_strobe_count: got %0d, expected 1", strobes - s0);
        end
    endtask

    initial begin
        rst_n    = 1'b1;
        d        = 8'h00;
        dk       = 1'b0;
        in_valid = 1'b0;
        test_reset();
        test_full_rate();
        test_k_flags();
        test_async_reset();
`ifndef BYTE_STRIP_PAD_EN
        test_gapped();
`else
        test_pad();
`endif
        test_reset_mid_group();
        drive(0, 8'h00, 0);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_groups: %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
